// File: rtl/conv_kernal_pkg.sv
// Shared definitions for the conv-layer-2 kernel store. The loader (writer)
// and the kernel reader both import this package so they agree on one
// address map: kernel num of channel ch lives at 25*num + 800*ch .. +24.
package conv_kernal_pkg;

  localparam int KERNEL_SIZE  = 25;
  localparam int NUM_KERNELS  = 32;
  localparam int NUM_CHANNELS = 32;
  localparam int TOTAL_WORDS  = KERNEL_SIZE * NUM_KERNELS * NUM_CHANNELS;
  localparam int ADDR_W       = 15;
  localparam int KW_W         = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/conv_kernal_2_loader_unpacker.sv
// kernal_byte_unpacker: holds one weight byte and presents it LSB first,
// one bit per shift, with a flag marking the eighth bit.
module kernal_byte_unpacker (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       last_o
);

  logic [7:0] sh_q;
  logic [2:0] idx_q;

  // Latch a new byte on load, otherwise shift right one bit per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sh_q  <= byte_i;
      idx_q <= '0;
    end else if (shift_i) begin
      sh_q  <= {1'b0, sh_q[7:1]};
      idx_q <= idx_q + 3'd1;
    end
  end

  assign bit_o  = sh_q[0];
  assign last_o = (idx_q == 3'd7);

endmodule

// File: rtl/conv_kernal_2_loader.sv
// conv_kernal_2_loader: unpacks a byte stream of binarized weights into the
// 1-bit conv_kernal_2 RAM (port A), sequential addresses 0..25599.
// Optional checksum stage: define CONV_KERNAL_LOADER_CHECKSUM_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | outputs idle, waiting for start
// WAIT_BYTE  | in_ready high, waiting for a weight byte
// SHIFT      | writing the 8 bits of the latched byte, one per cycle
// CHECK      | (checksum build) waiting for the single checksum byte
// DONE       | ok high; start restarts a full load
module conv_kernal_2_loader
  import conv_kernal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic              dina,
  output logic              kernel_done,
  output logic              busy,
  output logic              ok,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
  localparam logic [KW_W-1:0]   KW_LAST   = KW_W'(KERNEL_SIZE - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [KW_W-1:0]   kw_q, kw_d;
  logic              in_ready_q, wea_q, kd_q, busy_q, ok_q;
  logic              load, shift, clear;
  logic              bit_val, last_bit;

  kernal_byte_unpacker u_unpack (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .byte_i  (in_data),
    .shift_i (shift),
    .bit_o   (bit_val),
    .last_o  (last_bit)
  );

  // Next-state, counter advance and unpacker control.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kw_d    = kw_q;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT_BYTE;
          clear   = 1'b1;
        end
      end
      ST_WAIT_BYTE: begin
        if (in_valid && in_ready_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        // The final address is always a bit 7; stop without advancing so
        // the counter never leaves the store.
        if (addr_q == LAST_ADDR) begin
`ifdef CONV_KERNAL_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          kw_d   = (kw_q == KW_LAST) ? '0 : kw_q + KW_W'(1);
          if (last_bit) state_d = ST_WAIT_BYTE;
        end
      end
`ifdef CONV_KERNAL_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (in_valid && in_ready_q) state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      addr_d = '0;
      kw_d   = '0;
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      kw_q       <= '0;
      in_ready_q <= 1'b0;
      wea_q      <= 1'b0;
      kd_q       <= 1'b0;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      kw_q       <= kw_d;
      in_ready_q <= (state_d == ST_WAIT_BYTE) || (state_d == ST_CHECK);
      wea_q      <= (state_d == ST_SHIFT);
      kd_q       <= (state_d == ST_SHIFT) && (kw_d == KW_LAST);
      busy_q     <= (state_d == ST_WAIT_BYTE) || (state_d == ST_SHIFT) ||
                    (state_d == ST_CHECK);
      ok_q       <= (state_d == ST_DONE);
    end
  end

`ifdef CONV_KERNAL_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       chk_q, chk_d;

  // Running XOR of data bytes and the compare against the checksum byte.
  always_comb begin
    xor_d = xor_q;
    chk_d = chk_q;
    if (clear) begin
      xor_d = '0;
      chk_d = 1'b0;
    end else if (load) begin
      xor_d = xor_q ^ in_data;
    end else if ((state_q == ST_CHECK) && in_valid && in_ready_q) begin
      chk_d = (in_data != xor_q);
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= '0;
      chk_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      chk_q <= chk_d;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign wea         = wea_q;
  assign addra       = addr_q;
  assign dina        = bit_val;
  assign kernel_done = kd_q;
  assign busy        = busy_q;
  assign ok          = ok_q;

endmodule

// File: doc/conv_kernal_2_loader.md
# conv_kernal_2_loader

Writer side of the second-layer convolution-kernel store. Accepts a byte stream of binarized kernel weights, unpacks each byte into eight 1-bit words and writes them sequentially into the single-bit conv_kernal_2 RAM port A. Its address map is the one the kernel-reader FSM consumes: kernel `num` of input channel `channel` occupies addresses 25*num + 800*channel .. +24. It sits between the host/UART byte source and the kernel RAM, and must finish before the conv-layer-2 read path is enabled.

## Interface
- KERNEL_SIZE, 25, weights per kernel (5x5)
- NUM_KERNELS, 32, kernels per channel
- NUM_CHANNELS, 32, input channels
- ADDR_W, 15, RAM address width (total words 25600 must fit)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a full load
- in_data  in  8  weight byte; bit 0 is written first
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- wea  out  1  RAM write enable
- addra  out  ADDR_W  RAM write address
- dina  out  1  RAM write data
- kernel_done  out  1  one-cycle pulse on the write of each kernel's 25th weight
- busy  out  1  high from accepted start until DONE
- ok  out  1  level; all 25600 weights written, held until next accepted start
- chk_err  out  1  checksum mismatch flag (see Configuration)

## Operation
- FSM states: IDLE, WAIT_BYTE, SHIFT, CHECK (macro only), DONE.
- IDLE: outputs idle. start=1 -> WAIT_BYTE. Clears addr counter, kernel-weight counter (0..24), running XOR, ok, chk_err.
- WAIT_BYTE: in_ready=1. Handshake is in_valid & in_ready. On a handshake, latch in_data and go to SHIFT with bit index 0.
- SHIFT: 8 cycles. Each cycle: wea=1, dina=byte[bit], addra=addr counter. Then addr += 1 and bit += 1. The kernel-weight counter wraps 24->0, and kernel_done=1 in the cycle it reads 24.
- End of SHIFT, normal case: after bit 7 -> WAIT_BYTE.
- End of SHIFT, last address: the cycle writing address 25599 is a byte's bit 7, since 3200 bytes fill the store exactly. Go to CHECK if the macro is defined, else DONE.
- DONE: ok=1, busy=0, in_ready=0. start=1 -> restart exactly as from IDLE (ok drops the next cycle).
- start while busy is ignored.
- in_valid outside WAIT_BYTE/CHECK is ignored and no byte is consumed.
- Address counter never exceeds 25599. No write ever issues outside SHIFT.
- Reset values: in_ready, wea, dina, kernel_done, busy, ok and chk_err are 0; addra is 0; FSM is in IDLE. Reset during SHIFT forces wea=0 immediately (asynchronous); the partial load is abandoned.

## Timing
- start accepted at edge T -> in_ready=1 from T+1.
- Byte handshake at edge H -> writes on cycles H+1..H+8 -> in_ready=1 again at H+9.
- Peak throughput is 1 byte per 9 cycles. A full load takes at least 3200*9 cycles after start.
- ok rises on the cycle after the final write (address 25599), or on the cycle after the CHECK handshake.
- kernel_done is coincident with wea for addresses 24, 49, ..., 25599.
- All outputs are registered; no combinational path from in_valid to in_ready.

## Configuration
- CONV_KERNAL_LOADER_CHECKSUM_EN defined:
  - The FSM keeps a running XOR of all 3200 data bytes.
  - After the last SHIFT it enters CHECK with in_ready=1 and accepts exactly one checksum byte.
  - chk_err is set to (byte != XOR), then the FSM goes to DONE.
  - chk_err holds until the next accepted start.
  - ok rises regardless of chk_err.
- Not defined: there is no CHECK state, no XOR register, and chk_err is tied to 0.

## Structure
- Shared package conv_kernal_pkg holds:
  - KERNEL_SIZE, NUM_KERNELS, NUM_CHANNELS, the derived total word count (25600) and ADDR_W;
  - the loader state enum.
  The kernel reader uses the same package so both ends share one address map.
- One natural sub-module, kernal_byte_unpacker: latches a byte, presents bit[i] and a last-bit flag over 8 cycles. The FSM and counters stay in the top.

## Test plan
- First byte: start, then byte 0xA5 -> wea high 8 cycles at addra 0..7 with dina 1,0,1,0,0,1,0,1; in_ready returns 9 cycles after the handshake.
- Kernel boundary: bytes 0x00,0x00,0x00,0xFF -> single kernel_done pulse, coincident with the write of addra 24 (bit 0 of byte 4), dina=1.
- Full load with bytes 0..255 repeating -> exactly 25600 writes, last at addra 25599, ok=1 the next cycle, busy=0; a RAM model matches bit-for-bit. A repeated start clears ok and restarts at addra 0.
- Robustness:
  - start pulsed mid-load is ignored; addra continues.
  - in_valid held high during SHIFT does not consume extra bytes; the byte count stays 3200.
- Reset mid-load: assert rst during the SHIFT of byte 100 -> wea=0 in the same cycle; after release the FSM is in IDLE, addra=0 and ok=0, and a fresh load completes normally.
- With CONV_KERNAL_LOADER_CHECKSUM_EN:
  - 3200 bytes of 0x5A, then checksum 0x00 -> chk_err=0 and ok=1.
  - The same load with checksum 0x01 -> chk_err=1 and ok=1.
